pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter: DW, 32, payload width in bits.
REQ-002 SHALL have parameter: CNT_W, 16, width of each statistics counter.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: in_valid  input  1  upstream payload valid.
REQ-006 SHALL have port: in_ready  output  1  stage accepts payload this cycle.
REQ-007 SHALL have port: in_data  input  DW  upstream payload.
REQ-008 SHALL have port: hold  input  1  hazard freeze (e.g. load-use): no new payload accepted.
REQ-009 SHALL have port: flush  input  1  branch-mispredict kill of all held payloads.
REQ-010 SHALL have port: out_valid  output  1  downstream payload valid.
REQ-011 SHALL have port: out_ready  input  1  downstream accepts payload.
REQ-012 SHALL have port: out_data  output  DW  downstream payload.
REQ-013 SHALL have port: stall_cnt  output  CNT_W  cycles with in_valid=1 and in_ready=0.
REQ-014 SHALL have port: flush_cnt  output  CNT_W  cycles with flush=1.

Function
REQ-015 SHALL implement states EMPTY (no entry), FULL (main entry valid), plus SKID (main and skid entries valid) when the skid option is compiled in.
REQ-016 SHALL drive out_valid=1 in FULL/SKID, 0 in EMPTY; out_data = main entry; out_data = 0 whenever out_valid=0.
REQ-017 SHALL transfer in when in_valid & in_ready; transfer out when out_valid & out_ready; latency in->out exactly 1 cycle from EMPTY.
REQ-018 SHALL, without skid: in_ready = ~hold & ~flush & (~out_valid | out_ready) (combinational from out_ready).
REQ-019 SHALL, with skid: in_ready = ~hold & ~flush & (state != SKID), with no combinational path from out_ready to in_ready.
REQ-020 SHALL transition EMPTY->FULL on transfer in; FULL->FULL on simultaneous in and out (main replaced); FULL->EMPTY on out only; FULL->SKID on in without out (skid build only); SKID->FULL on out (skid entry moves to main, order preserved).
REQ-021 SHALL, on hold=1, keep stored entries unchanged except for out transfers, so draining under hold yields EMPTY and out_valid=0 (bubble).
REQ-022 SHALL, on flush=1, go to EMPTY next cycle regardless of hold, in_valid or out_ready; flush dominates hold; stored data cleared to 0.
REQ-023 SHALL never drop or duplicate a payload absent flush; a payload presented with in_ready=0 is not accepted.
REQ-024 SHALL increment stall_cnt and flush_cnt by 1 per qualifying cycle, saturating at 2^CNT_W-1 (no wrap).

Reset
REQ-025 SHALL, while rst=1, force state EMPTY, out_valid=0, out_data=0, skid entry=0, stall_cnt=0, flush_cnt=0; rst dominates flush and hold.
REQ-026 SHALL drive in_ready=0 while rst=1; first acceptance possible in the first cycle after rst deasserts.

Configuration
REQ-027 SHALL compile the second (skid) entry and SKID state only when macro PIPE_STAGE_SKID_EN is defined: full throughput with registered in_ready; without it, single entry, combinational in_ready per REQ-018.

Verification
REQ-028 SHALL cover: reset then in_data=0x0000_00A5 in_valid=1 out_ready=1 -> out_valid=1, out_data=0xA5 next cycle.
REQ-029 SHALL cover: FULL with 0x11, hold=1 for 3 cycles, out_ready=1, in_valid=1 -> 0x11 out once, then out_valid=0, stall_cnt=3.
REQ-030 SHALL cover: FULL (and SKID if enabled) with hold=1 and flush=1 same cycle -> EMPTY, out_data=0, flush_cnt=1.
REQ-031 SHALL cover (skid build): out_ready=0 while 0x1,0x2 sent -> in_ready=0 after second; out_ready=1 -> 0x1 then 0x2, no loss.
REQ-032 SHALL cover: CNT_W=4, in_valid=1 hold=1 for 20 cycles -> stall_cnt saturates at 15.
REQ-033 SHALL cover: rst=1 asserted mid-stream in SKID/FULL -> all outputs 0 next cycle, counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage with hold/flush control and saturating stall/flush counters.
// Define PIPE_STAGE_SKID_EN to add a skid entry for full throughput with registered in_ready.
module pipe_stage_reg #(
  parameter int unsigned DW    = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  input  logic             hold,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DW-1:0]    out_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

`ifdef PIPE_STAGE_SKID_EN
  typedef enum logic [1:0] {StEmpty = 2'd0, StFull = 2'd1, StSkid = 2'd2} state_e;
`else
  typedef enum logic [1:0] {StEmpty = 2'd0, StFull = 2'd1} state_e;
`endif

  state_e           state_q, state_d;
  logic [DW-1:0]    main_q, main_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             xfer_in, xfer_out;

`ifdef PIPE_STAGE_SKID_EN
  logic [DW-1:0]    skid_q, skid_d;
`endif

  assign out_valid = (state_q != StEmpty);
  assign out_data  = out_valid ? main_q : '0;

`ifdef PIPE_STAGE_SKID_EN
  // Registered-only dependence on downstream: out_ready never reaches in_ready.
  assign in_ready = ~rst & ~hold & ~flush & (state_q != StSkid);
`else
  assign in_ready = ~rst & ~hold & ~flush & (~out_valid | out_ready);
`endif

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
`ifdef PIPE_STAGE_SKID_EN
    skid_d  = skid_q;
`endif
    case (state_q)
      StEmpty: begin
        if (xfer_in) begin
          state_d = StFull;
          main_d  = in_data;
        end
      end
      StFull: begin
        if (xfer_in && xfer_out) begin
          main_d = in_data;
        end else if (xfer_out) begin
          state_d = StEmpty;
          main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
        end else if (xfer_in) begin
          state_d = StSkid;
          skid_d  = in_data;
`endif
        end
      end
`ifdef PIPE_STAGE_SKID_EN
      StSkid: begin
        if (xfer_out) begin
          state_d = StFull;
          main_d  = skid_q;
          skid_d  = '0;
        end
      end
`endif
      default: begin
        state_d = StEmpty;
        main_d  = '0;
      end
    endcase
    // Flush kills everything held, regardless of hold or handshakes.
    if (flush) begin
      state_d = StEmpty;
      main_d  = '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_d  = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StEmpty;
      main_q  <= '0;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
`ifdef PIPE_STAGE_SKID_EN
      skid_q  <= skid_d;
`endif
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_valid && !in_ready && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic
// checked against a queue-based model of the stage.
module tb_pipe_stage_reg;
`ifdef PIPE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic        clk, rst, in_valid, hold, flush, out_ready;
  logic [31:0] in_data;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [15:0] stall_cnt, flush_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_data4;
  logic [3:0]  stall_cnt4, flush_cnt4;

  int checks = 0;
  int errors = 0;

  logic [31:0] q[$];
  int unsigned m_stall, m_flush;

  pipe_stage_reg #(.DW(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .hold(hold), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_reg #(.DW(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
    .hold(hold), .flush(flush), .out_valid(out_valid4), .out_ready(out_ready),
    .out_data(out_data4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit exp_ready();
    if (rst || hold || flush) return 1'b0;
    if (CAP == 2) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  function automatic int unsigned sat(int unsigned v, int unsigned mx);
    return (v > mx) ? mx : v;
  endfunction

  // Advance one clock and apply the stage's rules to the model.
  task automatic tick();
    bit acc, pop, st;
    acc = in_valid && exp_ready();
    pop = (q.size() > 0) && out_ready;
    st  = in_valid && !exp_ready();
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_stall = 0;
      m_flush = 0;
    end else begin
      if (st) m_stall++;
      if (flush) begin
        q.delete();
        m_flush++;
      end else begin
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(in_data);
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; hold = 0; flush = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    tick();
    rst = 0;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; in_valid = 1; in_data = 32'h55; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %0b want 0", in_ready);
    end
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0)
    begin
      errors++;
      $display("FAIL reset_state got v=%0b d=%h s=%0d f=%0d want 0", out_valid, out_data,
               stall_cnt, flush_cnt);
    end
    rst = 0; in_valid = 0;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_first_ready got %0b want 1", in_ready);
    end
  endtask

  task automatic test_basic();
    do_reset();
    in_valid = 1; in_data = 32'h0000_00A5; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL basic_pre got r=%0b v=%0b want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
      errors++; $display("FAIL basic_latency got v=%0b d=%h want 1 a5", out_valid, out_data);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      errors++; $display("FAIL basic_drain got v=%0b d=%h want 0 0", out_valid, out_data);
    end
  endtask

  task automatic test_hold();
    int outs;
    do_reset();
    in_valid = 1; in_data = 32'h11;
    tick();
    in_data = 32'h22; hold = 1; out_ready = 1;
    outs = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready cyc %0d got %0b want 0", i, in_ready);
      end
      if (out_valid === 1'b1) begin
        outs++;
        checks++;
        if (out_data !== 32'h11) begin
          errors++; $display("FAIL hold_data got %h want 11", out_data);
        end
      end
      tick();
    end
    checks++;
    if (outs != 1 || out_valid !== 1'b0 || stall_cnt !== 16'd3) begin
      errors++;
      $display("FAIL hold_drain got outs=%0d v=%0b stall=%0d want 1 0 3", outs, out_valid,
               stall_cnt);
    end
  endtask

  task automatic test_flush_hold();
    do_reset();
    in_valid = 1; in_data = 32'hAA;
    tick();
    if (CAP == 2) begin
      in_data = 32'hBB;
      tick();
    end
    in_valid = 1; hold = 1; flush = 1; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL flush_ready got %0b want 0", in_ready);
    end
    tick();
    idle_inputs();
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || flush_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_hold got v=%0b d=%h f=%0d want 0 0 1", out_valid, out_data,
               flush_cnt);
    end
    out_ready = 1;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_no_skid_left got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 1; in_data = 32'h1;
    tick();
    if (CAP == 2) begin
      in_data = 32'h2;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL bp_second_ready got %0b want 1", in_ready);
      end
      tick();
    end
    in_data = 32'h3;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_full_ready got %0b want 0", in_ready);
    end
    in_valid = 0; out_ready = 1;
    for (int i = 1; i <= CAP; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'(i)) begin
        errors++; $display("FAIL bp_order got v=%0b d=%h want 1 %h", out_valid, out_data, i);
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_empty got v=%0b want 0", out_valid);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    in_valid = 1; hold = 1;
    for (int i = 0; i < 20; i++) tick();
    checks++;
    if (stall_cnt4 !== 4'd15 || stall_cnt !== 16'd20) begin
      errors++;
      $display("FAIL stall_sat got s4=%0d s16=%0d want 15 20", stall_cnt4, stall_cnt);
    end
    hold = 0; in_valid = 0; flush = 1;
    for (int i = 0; i < 17; i++) tick();
    checks++;
    if (flush_cnt4 !== 4'd15 || flush_cnt !== 16'd17) begin
      errors++;
      $display("FAIL flush_sat got f4=%0d f16=%0d want 15 17", flush_cnt4, flush_cnt);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    flush = 1;
    tick();
    flush = 0; in_valid = 1; in_data = 32'h77;
    for (int i = 0; i < 3; i++) tick();
    hold = 1; in_valid = 1;
    tick();
    rst = 1; out_ready = 1;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("FAIL midrst_ready got %0b want 0", in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || stall_cnt !== 16'h0 || flush_cnt !== 16'h0)
    begin
      errors++;
      $display("FAIL midrst_state got v=%0b d=%h s=%0d f=%0d want 0", out_valid, out_data,
               stall_cnt, flush_cnt);
    end
    rst = 0;
    idle_inputs();
    #1;
  endtask

  task automatic test_random();
    logic [31:0] exp_d;
    bit exp_r, exp_v;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 49) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      hold      = ($urandom_range(0, 4) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      #1;
      exp_r = exp_ready();
      exp_v = (q.size() > 0);
      exp_d = exp_v ? q[0] : 32'h0;
      checks++;
      if (in_ready !== exp_r || in_ready4 !== exp_r) begin
        errors++; $display("FAIL rnd_ready cyc %0d got %0b/%0b want %0b", i, in_ready,
                           in_ready4, exp_r);
      end
      checks++;
      if (out_valid !== exp_v || out_data !== exp_d || out_data4 !== exp_d) begin
        errors++; $display("FAIL rnd_out cyc %0d got v=%0b d=%h want v=%0b d=%h", i,
                           out_valid, out_data, exp_v, exp_d);
      end
      checks++;
      if (stall_cnt !== 16'(sat(m_stall, 65535)) || flush_cnt !== 16'(sat(m_flush, 65535)) ||
          stall_cnt4 !== 4'(sat(m_stall, 15)) || flush_cnt4 !== 4'(sat(m_flush, 15))) begin
        errors++; $display("FAIL rnd_cnt cyc %0d got s=%0d f=%0d s4=%0d f4=%0d want s=%0d f=%0d",
                           i, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4, m_stall, m_flush);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1;
    m_stall = 0;
    m_flush = 0;
    idle_inputs();
    test_reset();
    test_basic();
    test_hold();
    test_flush_hold();
    test_backpressure();
    test_saturate();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
